// File: rtl/user_wb_slave_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : user_wb_slave_arbiter
//  Purpose  : Single-master Wishbone router between the management SoC user
//             port and the user project slaves. Each access is decoded into
//             one of NUM_SLAVES equal address windows, the debug window (top
//             two words of the 1 MB user space) or unmapped space. One
//             transaction is sequenced at a time. Hung accesses are ended by
//             a watchdog that raises a sticky interrupt.
//  Ports    :
//    wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//    wbs_cyc_i/stb_i/we_i/sel_i   master request
//    wbs_adr_i, wbs_dat_i         master address / write data
//    wbs_ack_o, wbs_dat_o         registered ack / read data to master
//    slv_cyc_o                    one-hot slave cycle (bit NUM_SLAVES = debug)
//    slv_stb_o                    registered shared strobe
//    slv_we_o/sel_o/adr_o/dat_o   combinational pass-through of the master
//    slv_ack_i, slv_dat_i         per-slave ack / read data (slave k at 32k)
//    to_irq_o, to_irq_clr_i       sticky timeout interrupt and its clear
//    to_adr_o, to_count_o         last timed-out address, saturating count
//  Revision : 1.0  initial release
// ============================================================================
module user_wb_slave_arbiter #(
   parameter int NUM_SLAVES = 4,
   parameter int WIN_BITS   = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_ni,
   input  logic                         wbs_cyc_i,
   input  logic                         wbs_stb_i,
   input  logic                         wbs_we_i,
   input  logic [3:0]                   wbs_sel_i,
   input  logic [31:0]                  wbs_adr_i,
   input  logic [31:0]                  wbs_dat_i,
   output logic                         wbs_ack_o,
   output logic [31:0]                  wbs_dat_o,
   output logic [NUM_SLAVES:0]          slv_cyc_o,
   output logic                         slv_stb_o,
   output logic                         slv_we_o,
   output logic [3:0]                   slv_sel_o,
   output logic [31:0]                  slv_adr_o,
   output logic [31:0]                  slv_dat_o,
   input  logic [NUM_SLAVES:0]          slv_ack_i,
   input  logic [32*(NUM_SLAVES+1)-1:0] slv_dat_i,
   output logic                         to_irq_o,
   input  logic                         to_irq_clr_i,
   output logic [31:0]                  to_adr_o,
   output logic [7:0]                   to_count_o
);

   localparam int IDX_W  = $clog2(NUM_SLAVES);
   // One extra bit so the debug port index NUM_SLAVES is representable.
   localparam int IDXS_W = IDX_W + 1;
   localparam int NS1    = NUM_SLAVES + 1;
   localparam int ARR    = 1 << IDXS_W;
   localparam int WD_W   = 10;

   localparam logic [31:0] DAT_UNMAPPED = 32'hDEAD_BEEF;
   localparam logic [31:0] DAT_TIMEOUT  = 32'hBADC_0FFE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [IDXS_W-1:0]   idx_q, idx_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                ack_q, ack_d;
   logic [31:0]         dat_q, dat_d;
   logic [NUM_SLAVES:0] cyc_q, cyc_d;
   logic                stb_q, stb_d;
   logic                irq_q, irq_d;
   logic [31:0]         to_adr_q, to_adr_d;
   logic [7:0]          to_cnt_q, to_cnt_d;

   // ---------------------------------------------------------------------
   // Address decode (only meaningful while IDLE)
   // ---------------------------------------------------------------------
   logic              w_dbg_hit;
   logic              w_usr_hit;
   logic              w_mapped;
   logic [19:0]       w_adr_win;
   logic [IDXS_W-1:0] w_dec_idx;

   assign w_adr_win = wbs_adr_i[19:0];
   assign w_dbg_hit = (wbs_adr_i[19:3] == 17'h1ffff);
   // Bits above the slave index must be zero; when the windows tile the
   // whole 1 MB space the shift leaves nothing and every address maps.
   assign w_usr_hit = ((w_adr_win >> (WIN_BITS + IDX_W)) == 20'd0);
   assign w_mapped  = w_dbg_hit | w_usr_hit;
   // Debug window overlaps the last user window's space, so it wins.
   assign w_dec_idx = w_dbg_hit ? IDXS_W'(NUM_SLAVES)
                                : {1'b0, wbs_adr_i[WIN_BITS +: IDX_W]};

   // ---------------------------------------------------------------------
   // Per-slave return path, padded to a power of two so any idx value
   // selects a defined (zero) entry.
   // ---------------------------------------------------------------------
   logic [31:0]    w_rd_dat [ARR];
   logic [ARR-1:0] w_ack_vec;

   for (genvar k = 0; k < ARR; k++) begin : g_ret
      if (k < NS1) begin : g_real
         assign w_rd_dat[k]  = slv_dat_i[32*k +: 32];
         assign w_ack_vec[k] = slv_ack_i[k];
      end else begin : g_pad
         assign w_rd_dat[k]  = 32'd0;
         assign w_ack_vec[k] = 1'b0;
      end
   end

   logic        w_sel_ack;
   logic [31:0] w_sel_dat;
   logic        w_wd_exp;
   logic        w_to_set;

   assign w_sel_ack = w_ack_vec[idx_q];
   assign w_sel_dat = w_rd_dat[idx_q];
   assign w_wd_exp  = (wd_q == WD_W'(TIMEOUT - 1));

   // ---------------------------------------------------------------------
   // Next-state / next-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wd_d     = wd_q;
      ack_d    = 1'b0;
      dat_d    = dat_q;
      cyc_d    = '0;
      stb_d    = 1'b0;
      to_adr_d = to_adr_q;
      to_cnt_d = to_cnt_q;
      w_to_set = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               idx_d = w_dec_idx;
               if (w_mapped) begin
                  state_d = ST_BUSY;
                  wd_d    = '0;
                  cyc_d   = NS1'(1) << w_dec_idx;
                  stb_d   = 1'b1;
               end else begin
                  state_d = ST_RESP;
                  ack_d   = 1'b1;
                  dat_d   = DAT_UNMAPPED;
               end
            end
         end

         ST_BUSY: begin
            if (!wbs_cyc_i) begin
               // Master abandoned the cycle: release the slave, no ack.
               state_d = ST_IDLE;
            end else if (w_sel_ack) begin
               state_d = ST_RESP;
               ack_d   = 1'b1;
               dat_d   = w_sel_dat;
            end else if (w_wd_exp) begin
               state_d  = ST_RESP;
               ack_d    = 1'b1;
               dat_d    = DAT_TIMEOUT;
               w_to_set = 1'b1;
               to_adr_d = wbs_adr_i;
               to_cnt_d = (to_cnt_q == 8'hFF) ? 8'hFF : to_cnt_q + 8'd1;
            end else begin
               wd_d  = wd_q + WD_W'(1);
               cyc_d = NS1'(1) << idx_q;
               stb_d = 1'b1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new timeout beats a simultaneous clear.
      if (w_to_set) begin
         irq_d = 1'b1;
      end else if (to_irq_clr_i) begin
         irq_d = 1'b0;
      end else begin
         irq_d = irq_q;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         wd_q     <= '0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
         cyc_q    <= '0;
         stb_q    <= 1'b0;
         irq_q    <= 1'b0;
         to_adr_q <= '0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wd_q     <= wd_d;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         cyc_q    <= cyc_d;
         stb_q    <= stb_d;
         irq_q    <= irq_d;
         to_adr_q <= to_adr_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign slv_cyc_o  = cyc_q;
   assign slv_stb_o  = stb_q;
   assign to_irq_o   = irq_q;
   assign to_adr_o   = to_adr_q;
   assign to_count_o = to_cnt_q;

   // Shared request fields: the master holds these stable for the cycle.
   assign slv_we_o  = wbs_we_i;
   assign slv_sel_o = wbs_sel_i;
   assign slv_adr_o = wbs_adr_i;
   assign slv_dat_o = wbs_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_user_wb_slave_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_user_wb_slave_arbiter
//  Purpose  : Directed, table-driven bench for user_wb_slave_arbiter with
//             NUM_SLAVES=4, WIN_BITS=16, TIMEOUT=255. A simple slave model
//             acks after a programmable number of wait states; hand-written
//             sequences cover abort, irq clear and asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_user_wb_slave_arbiter;

   localparam int NS1 = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]        wbs_sel_i;
   logic [31:0]       wbs_adr_i, wbs_dat_i;
   logic              wbs_ack_o;
   logic [31:0]       wbs_dat_o;
   logic [NS1-1:0]    slv_cyc_o;
   logic              slv_stb_o, slv_we_o;
   logic [3:0]        slv_sel_o;
   logic [31:0]       slv_adr_o, slv_dat_o;
   logic [NS1-1:0]    slv_ack_i;
   logic [32*NS1-1:0] slv_dat_i;
   logic              to_irq_o, to_irq_clr_i;
   logic [31:0]       to_adr_o;
   logic [7:0]        to_count_o;

   always #5 clk = ~clk;

   user_wb_slave_arbiter #(
      .NUM_SLAVES (4),
      .WIN_BITS   (16),
      .TIMEOUT    (255)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .wbs_cyc_i    (wbs_cyc_i),
      .wbs_stb_i    (wbs_stb_i),
      .wbs_we_i     (wbs_we_i),
      .wbs_sel_i    (wbs_sel_i),
      .wbs_adr_i    (wbs_adr_i),
      .wbs_dat_i    (wbs_dat_i),
      .wbs_ack_o    (wbs_ack_o),
      .wbs_dat_o    (wbs_dat_o),
      .slv_cyc_o    (slv_cyc_o),
      .slv_stb_o    (slv_stb_o),
      .slv_we_o     (slv_we_o),
      .slv_sel_o    (slv_sel_o),
      .slv_adr_o    (slv_adr_o),
      .slv_dat_o    (slv_dat_o),
      .slv_ack_i    (slv_ack_i),
      .slv_dat_i    (slv_dat_i),
      .to_irq_o     (to_irq_o),
      .to_irq_clr_i (to_irq_clr_i),
      .to_adr_o     (to_adr_o),
      .to_count_o   (to_count_o)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // slot: target slave (-1 none); wait_n: wait states before ack (-1 never)
   // noise: acks driven on other slaves; clr_at: cycle to pulse irq clear
   typedef struct {
      logic [31:0] adr;
      logic        we;
      int          slot;
      int          wait_n;
      logic [31:0] sdat;
      logic [4:0]  noise;
      logic [4:0]  exp_cyc;
      int          exp_lat;
      logic [31:0] exp_dat;
      int          clr_at;
      logic        exp_irq;
      logic [7:0]  exp_cnt;
      logic [31:0] exp_toadr;
   } vec_t;

   vec_t tbl [9];

   task automatic set_slv_dat(input int slot, input logic [31:0] sdat);
      for (int k = 0; k < NS1; k++)
         slv_dat_i[32*k +: 32] = (k == slot) ? sdat : (32'hFFFF_0000 | 32'(k));
   endtask

   task automatic idle_master();
      wbs_cyc_i    = 1'b0;
      wbs_stb_i    = 1'b0;
      wbs_we_i     = 1'b0;
      slv_ack_i    = '0;
      to_irq_clr_i = 1'b0;
   endtask

   // Called just after a falling edge; request is sampled at the next rising
   // edge, which starts cycle 1.
   task automatic run_txn(input vec_t v, input int id);
      logic [4:0]  cyc_u;
      logic [4:0]  ackv;
      logic [31:0] rdat;
      bit          stb_bad;
      int          busy;
      int          lat;
      cyc_u = '0; rdat = '0; stb_bad = 1'b0; busy = 0; lat = 0;
      set_slv_dat(v.slot, v.sdat);
      wbs_adr_i = v.adr;
      wbs_we_i  = v.we;
      wbs_sel_i = 4'hF;
      wbs_dat_i = 32'h5555_0000 | 32'(id);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      slv_ack_i = v.noise;
      #1;
      check($sformatf("v%0d_pass_adr", id), slv_adr_o, v.adr);
      check($sformatf("v%0d_pass_dat_we", id), {slv_dat_o[30:0], slv_we_o},
            {wbs_dat_i[30:0], v.we});
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         cyc_u = cyc_u | slv_cyc_o;
         if (slv_cyc_o != '0 && !slv_stb_o) stb_bad = 1'b1;
         if (wbs_ack_o) begin
            lat  = n;
            rdat = wbs_dat_o;
            break;
         end
         ackv = v.noise;
         if (v.slot >= 0 && slv_cyc_o[v.slot]) begin
            if (busy == v.wait_n) ackv[v.slot] = 1'b1;
            busy++;
         end
         slv_ack_i    = ackv;
         to_irq_clr_i = (n == v.clr_at);
      end
      idle_master();
      check($sformatf("v%0d_cyc", id), 32'(cyc_u), 32'(v.exp_cyc));
      check($sformatf("v%0d_stb", id), 32'(stb_bad), 32'd0);
      check($sformatf("v%0d_lat", id), 32'(lat), 32'(v.exp_lat));
      check($sformatf("v%0d_dat", id), rdat, v.exp_dat);
      @(negedge clk);
      check($sformatf("v%0d_ack_once", id), 32'(wbs_ack_o), 32'd0);
      check($sformatf("v%0d_cyc_after", id), 32'(slv_cyc_o), 32'd0);
      check($sformatf("v%0d_irq", id), 32'(to_irq_o), 32'(v.exp_irq));
      check($sformatf("v%0d_cnt", id), 32'(to_count_o), 32'(v.exp_cnt));
      check($sformatf("v%0d_toadr", id), to_adr_o, v.exp_toadr);
   endtask

   initial begin
      logic acc;

      tbl[0] = '{32'h3001_0004, 1'b0,  1,  0, 32'h1234_5678, 5'b00000, 5'b00010,   2, 32'h1234_5678,   0, 1'b0, 8'd0, 32'h0};
      tbl[1] = '{32'h300F_FFF8, 1'b1,  4,  3, 32'hCAFE_0004, 5'b00000, 5'b10000,   5, 32'hCAFE_0004,   0, 1'b0, 8'd0, 32'h0};
      tbl[2] = '{32'h3004_0000, 1'b0, -1, -1, 32'h0,         5'b00000, 5'b00000,   1, 32'hDEAD_BEEF,   0, 1'b0, 8'd0, 32'h0};
      tbl[3] = '{32'h300F_FFF0, 1'b0, -1, -1, 32'h0,         5'b00000, 5'b00000,   1, 32'hDEAD_BEEF,   0, 1'b0, 8'd0, 32'h0};
      tbl[4] = '{32'h300F_FFFC, 1'b0,  4,  0, 32'h0BAD_D00D, 5'b00000, 5'b10000,   2, 32'h0BAD_D00D,   0, 1'b0, 8'd0, 32'h0};
      tbl[5] = '{32'h3003_0010, 1'b0,  3,  1, 32'hA5A5_0003, 5'b10111, 5'b01000,   3, 32'hA5A5_0003,   0, 1'b0, 8'd0, 32'h0};
      tbl[6] = '{32'h3000_0000, 1'b1,  0,  0, 32'h0000_0001, 5'b00000, 5'b00001,   2, 32'h0000_0001,   0, 1'b0, 8'd0, 32'h0};
      tbl[7] = '{32'h3002_0000, 1'b0,  2, -1, 32'h7777_7777, 5'b11011, 5'b00100, 256, 32'hBADC_0FFE,   0, 1'b1, 8'd1, 32'h3002_0000};
      tbl[8] = '{32'h3002_0004, 1'b0,  2, -1, 32'h7777_7777, 5'b00000, 5'b00100, 256, 32'hBADC_0FFE, 255, 1'b1, 8'd2, 32'h3002_0004};

      rst_n     = 1'b0;
      wbs_adr_i = '0;
      wbs_dat_i = '0;
      wbs_sel_i = '0;
      slv_dat_i = '0;
      idle_master();
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_ack", 32'(wbs_ack_o), 32'd0);
      check("rst_dat", wbs_dat_o, 32'd0);
      check("rst_cyc_stb", 32'({slv_cyc_o, slv_stb_o}), 32'd0);
      check("rst_irq_cnt", 32'({to_irq_o, to_count_o}), 32'd0);
      check("rst_toadr", to_adr_o, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_txn(tbl[i], i);

      // Master abort in BUSY, then a late ack from slave 0
      set_slv_dat(0, 32'h0A0A_0A0A);
      wbs_adr_i = 32'h3000_0100;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      @(negedge clk);
      check("abort_cyc", 32'(slv_cyc_o), 32'b00001);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      @(negedge clk);
      check("abort_drop", 32'({slv_cyc_o, slv_stb_o}), 32'd0);
      slv_ack_i = 5'b00001;
      acc = 1'b0;
      repeat (3) begin
         @(negedge clk);
         acc = acc | wbs_ack_o;
      end
      check("abort_no_ack", 32'(acc), 32'd0);
      slv_ack_i = '0;
      run_txn(tbl[5], 15);

      // First timeout, then a lone clear, then a timeout with clear on the
      // same edge as the set
      run_txn(tbl[7], 7);
      to_irq_clr_i = 1'b1;
      @(negedge clk);
      to_irq_clr_i = 1'b0;
      check("clr_irq", 32'(to_irq_o), 32'd0);
      check("clr_keeps_cnt", 32'(to_count_o), 32'd1);
      run_txn(tbl[8], 8);

      // Asynchronous reset in the middle of a BUSY access
      set_slv_dat(2, 32'h0);
      wbs_adr_i = 32'h3002_0000;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      repeat (3) @(negedge clk);
      check("busy_cyc", 32'(slv_cyc_o), 32'b00100);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cyc_stb", 32'({slv_cyc_o, slv_stb_o}), 32'd0);
      check("arst_ack", 32'(wbs_ack_o), 32'd0);
      check("arst_cnt", 32'(to_count_o), 32'd0);
      check("arst_irq", 32'(to_irq_o), 32'd0);
      @(negedge clk);
      idle_master();
      rst_n = 1'b1;
      acc = 1'b0;
      repeat (3) begin
         @(negedge clk);
         acc = acc | wbs_ack_o;
      end
      check("arst_no_ack", 32'(acc), 32'd0);
      run_txn(tbl[0], 10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
